// File: rtl/led_pattern_sequencer_if.sv
// Pattern RAM read port shared by the LED sequencer (master) and the RAM (slave).
// Read data is expected one cycle after the read strobe.
interface led_pattern_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [31:0]       ram_rdata;

  modport master (
    output ram_addr,
    output ram_rd,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_rd,
    output ram_rdata
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Plays an LED pattern table from an external synchronous RAM.
// Each entry holds an LED value for a number of prescaled ticks; an END entry stops or loops.
module led_pattern_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int LED_W        = 4,
  parameter int CLK_PER_TICK = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic [ADDR_W-1:0]    base_addr,
  led_pattern_sequencer_if.master ram,
  output logic [LED_W-1:0]     led,
  output logic                 busy,
  output logic                 done
);

  localparam int PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_TICK - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_reg;
  logic              first_entry;
  logic [15:0]       dur_cnt;
  logic [PRE_W-1:0]  prescale;

  logic              entry_end;
  logic [15:0]       entry_dur;
  logic [LED_W-1:0]  entry_led;
  logic              unused_rdata;

  assign entry_end    = ram.ram_rdata[31];
  assign entry_dur    = ram.ram_rdata[23:8];
  assign entry_led    = ram.ram_rdata[LED_W-1:0];
  assign unused_rdata = ^{ram.ram_rdata[30:24], ram.ram_rdata[7:0]};

  // ram_rd is a one-cycle strobe raised on every transition into FETCH, so it is
  // cleared by default and only set where the next state is FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      base_reg     <= '0;
      first_entry  <= 1'b0;
      dur_cnt      <= '0;
      prescale     <= '0;
      ram.ram_addr <= '0;
      ram.ram_rd   <= 1'b0;
      led          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ram.ram_rd <= 1'b0;
      done       <= 1'b0;
      if (stop && (state != S_IDLE)) begin
        state <= S_IDLE;
        led   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              base_reg     <= base_addr;
              ram.ram_addr <= base_addr;
              ram.ram_rd   <= 1'b1;
              first_entry  <= 1'b1;
              busy         <= 1'b1;
              state        <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            if (!entry_end) begin
              led         <= entry_led;
              dur_cnt     <= (entry_dur == 16'd0) ? 16'd1 : entry_dur;
              prescale    <= '0;
              first_entry <= 1'b0;
              state       <= S_HOLD;
            end else if (loop_en && !first_entry) begin
              ram.ram_addr <= base_reg;
              ram.ram_rd   <= 1'b1;
              state        <= S_FETCH;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_HOLD: begin
            if (prescale == PRE_MAX) begin
              prescale <= '0;
              dur_cnt  <= dur_cnt - 16'd1;
              if (dur_cnt == 16'd1) begin
                ram.ram_addr <= ram.ram_addr + 1'b1;
                ram.ram_rd   <= 1'b1;
                state        <= S_FETCH;
              end
            end else begin
              prescale <= prescale + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a behavioural synchronous pattern RAM.
// Runs are captured cycle by cycle and compared against hand-computed timelines.
module tb_led_pattern_sequencer;

  localparam int ADDR_W = 10;
  localparam int LED_W  = 4;
  localparam int CPT    = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] base_addr;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic              done;

  led_pattern_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  led_pattern_sequencer #(
    .ADDR_W(ADDR_W),
    .LED_W(LED_W),
    .CLK_PER_TICK(CPT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .base_addr(base_addr),
    .ram(bus),
    .led(led),
    .busy(busy),
    .done(done)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [LED_W-1:0]  led_log  [0:63];
  logic              done_log [0:63];
  logic              busy_log [0:63];
  logic              rd_log   [0:63];
  logic [ADDR_W-1:0] addr_log [0:63];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    start = s;
    stop  = p;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic captureRun(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      led_log[i]  = led;
      done_log[i] = done;
      busy_log[i] = busy;
      rd_log[i]   = bus.ram_rd;
      addr_log[i] = bus.ram_addr;
      step(1);
    end
  endtask

  function automatic int countRd(input int first, input int last);
    int c = 0;
    for (int i = first; i <= last; i++) if (rd_log[i]) c++;
    return c;
  endfunction

  function automatic int countDone(input int first, input int last);
    int c = 0;
    for (int i = first; i <= last; i++) if (done_log[i]) c++;
    return c;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    base_addr = '0;
    step(3);

    checkOutput("rst_led",  32'(led), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_rd",   32'(bus.ram_rd), 32'h0);
    checkOutput("rst_addr", 32'(bus.ram_addr), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Basic play: led=1 for 14 cycles, led=2 for 6, then done.
    mem[0] = 32'h0000_0301;
    mem[1] = 32'h0000_0102;
    mem[2] = 32'h8000_0000;
    applyStimulus(1'b1, 1'b0);
    captureRun(0, 26);
    checkOutput("basic_led_load",  32'(led_log[1]), 32'h0);
    checkOutput("basic_led1_first", 32'(led_log[2]), 32'h1);
    checkOutput("basic_led1_last",  32'(led_log[15]), 32'h1);
    checkOutput("basic_led2_first", 32'(led_log[16]), 32'h2);
    checkOutput("basic_led2_last",  32'(led_log[21]), 32'h2);
    checkOutput("basic_led_after",  32'(led_log[24]), 32'h2);
    checkOutput("basic_done_early", 32'(done_log[21]), 32'h0);
    checkOutput("basic_done",       32'(done_log[22]), 32'h1);
    checkOutput("basic_done_count", 32'(countDone(0, 25)), 32'd1);
    checkOutput("basic_busy_before", 32'(busy_log[21]), 32'h1);
    checkOutput("basic_busy_fall",  32'(busy_log[22]), 32'h0);
    checkOutput("basic_rd_count",   32'(countRd(0, 25)), 32'd3);
    checkOutput("basic_rd0",   32'(rd_log[0]), 32'h1);
    checkOutput("basic_addr0", 32'(addr_log[0]), 32'd0);
    checkOutput("basic_rd1",   32'(rd_log[14]), 32'h1);
    checkOutput("basic_addr1", 32'(addr_log[14]), 32'd1);
    checkOutput("basic_rd2",   32'(rd_log[20]), 32'h1);
    checkOutput("basic_addr2", 32'(addr_log[20]), 32'd2);

    // Zero duration behaves like one tick.
    mem[0] = 32'h0000_0005;
    mem[1] = 32'h8000_0000;
    applyStimulus(1'b1, 1'b0);
    captureRun(0, 12);
    checkOutput("zero_led_first", 32'(led_log[2]), 32'h5);
    checkOutput("zero_led_last",  32'(led_log[7]), 32'h5);
    checkOutput("zero_done_early", 32'(done_log[7]), 32'h0);
    checkOutput("zero_done",      32'(done_log[8]), 32'h1);
    checkOutput("zero_rd_count",  32'(countRd(0, 11)), 32'd2);

    // Loop: END restarts at base, then dropping loop_en ends at the next END.
    mem[0]  = 32'h0000_0301;
    mem[1]  = 32'h0000_0102;
    loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    captureRun(0, 40);
    loop_en = 1'b0;
    captureRun(40, 10);
    checkOutput("loop_rd_restart",   32'(rd_log[22]), 32'h1);
    checkOutput("loop_addr_restart", 32'(addr_log[22]), 32'd0);
    checkOutput("loop_led_hold",     32'(led_log[23]), 32'h2);
    checkOutput("loop_led1_again",   32'(led_log[24]), 32'h1);
    checkOutput("loop_led1_last",    32'(led_log[37]), 32'h1);
    checkOutput("loop_led2_again",   32'(led_log[38]), 32'h2);
    checkOutput("loop_no_done",      32'(countDone(0, 43)), 32'd0);
    checkOutput("loop_busy",         32'(busy_log[43]), 32'h1);
    checkOutput("loop_exit_done",    32'(done_log[44]), 32'h1);
    checkOutput("loop_exit_busy",    32'(busy_log[44]), 32'h0);
    checkOutput("loop_exit_led",     32'(led_log[44]), 32'h2);

    // Start and stop together in idle: nothing happens.
    applyStimulus(1'b1, 1'b1);
    checkOutput("startstop_busy", 32'(busy), 32'h0);
    checkOutput("startstop_rd",   32'(bus.ram_rd), 32'h0);
    step(2);

    // Start while busy is ignored; stop aborts; a later start replays from base.
    applyStimulus(1'b1, 1'b0);
    step(5);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ign_rd",   32'(bus.ram_rd), 32'h0);
    step(9);
    checkOutput("ign_led1_last", 32'(led), 32'h1);
    step(1);
    checkOutput("ign_led2", 32'(led), 32'h2);
    step(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_busy", 32'(busy), 32'h0);
    checkOutput("stop_led",  32'(led), 32'h0);
    checkOutput("stop_done", 32'(done), 32'h0);
    checkOutput("stop_rd",   32'(bus.ram_rd), 32'h0);
    captureRun(0, 6);
    checkOutput("stop_no_done_after", 32'(countDone(0, 5)), 32'd0);
    checkOutput("stop_no_rd_after",   32'(countRd(0, 5)), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("replay_rd",   32'(bus.ram_rd), 32'h1);
    checkOutput("replay_addr", 32'(bus.ram_addr), 32'd0);
    step(2);
    checkOutput("replay_led", 32'(led), 32'h1);

    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // END at base with loop_en: done three cycles after start, no restart.
    mem[0]  = 32'h8000_0000;
    loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    captureRun(0, 8);
    loop_en = 1'b0;
    checkOutput("endbase_done_early", 32'(done_log[1]), 32'h0);
    checkOutput("endbase_done",      32'(done_log[2]), 32'h1);
    checkOutput("endbase_done_once", 32'(countDone(0, 7)), 32'd1);
    checkOutput("endbase_rd_count",  32'(countRd(0, 7)), 32'd1);
    checkOutput("endbase_busy",      32'(busy_log[2]), 32'h0);
    checkOutput("endbase_led",       32'(led_log[7]), 32'h0);

    // Address wrap from 1023 to 0.
    mem[1023] = 32'h0000_0109;
    mem[0]    = 32'h8000_0000;
    base_addr = 10'd1023;
    applyStimulus(1'b1, 1'b0);
    captureRun(0, 12);
    checkOutput("wrap_addr_first", 32'(addr_log[0]), 32'd1023);
    checkOutput("wrap_led",        32'(led_log[2]), 32'h9);
    checkOutput("wrap_rd_second",  32'(rd_log[6]), 32'h1);
    checkOutput("wrap_addr_second", 32'(addr_log[6]), 32'd0);
    checkOutput("wrap_done",       32'(done_log[8]), 32'h1);
    checkOutput("wrap_led_held",   32'(led_log[9]), 32'h9);

    // Asynchronous reset mid-HOLD clears outputs without a clock edge.
    applyStimulus(1'b1, 1'b0);
    step(3);
    checkOutput("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_led",  32'(led), 32'h0);
    checkOutput("async_rst_busy", 32'(busy), 32'h0);
    checkOutput("async_rst_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("async_rst_rd",   32'(bus.ram_rd), 32'h0);
    checkOutput("async_rst_done", 32'(done), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
